// File: rtl/alu_seq_if.sv
// Operand/opcode/result bundle for alu_seq; clk and rst_n stay plain ports.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [4:0]       select;
  logic             carry_in;
  logic             start;
  logic             enable;
  wire  [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic             zero_flag;
  logic             neg_flag;
  logic             ovf_flag;

  modport master (
    output in_1, in_2, select, carry_in, start, enable,
    input  data, busy, done, carry_out, zero_flag, neg_flag, ovf_flag
  );

  modport slave (
    input  in_1, in_2, select, carry_in, start, enable,
    output data, busy, done, carry_out, zero_flag, neg_flag, ovf_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU: operands latched on start, single-cycle ops finish in one
// clock, variable shifts and shift-add multiply iterate one step per clock.
module alu_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW:0] CNT_ONE   = (CW+1)'(1);
  localparam logic [CW:0] CNT_WIDTH = (CW+1)'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_PSA  = 5'd8;
  localparam logic [4:0] OP_PSB  = 5'd9;
  localparam logic [4:0] OP_SHL1 = 5'd10;
  localparam logic [4:0] OP_SHR1 = 5'd11;
  localparam logic [4:0] OP_ASR1 = 5'd12;
  localparam logic [4:0] OP_ROL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_INC  = 5'd15;
  localparam logic [4:0] OP_DEC  = 5'd16;
  localparam logic [4:0] OP_SHLN = 5'd17;
  localparam logic [4:0] OP_SHRN = 5'd18;
  localparam logic [4:0] OP_MUL  = 5'd19;

  localparam int unsigned MSB = WIDTH - 1;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, result_q;
  logic [4:0]       op_q;
  logic             cin_q, sc_q;
  logic [CW:0]      cnt_q;
  logic             done_q, c_q, z_q, n_q, v_q;

  logic             mul_in, multi_in;
  logic [WIDTH:0]   ext, mul_sum;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d;

  // Classify the incoming opcode as iterative or single-cycle
  always_comb begin
    mul_in   = MUL_EN && (bus.select == OP_MUL);
    multi_in = mul_in || (bus.select == OP_SHLN) || (bus.select == OP_SHRN);
  end

  // One shift-add step: add A into the high half when the multiplier LSB is set
  always_comb begin
    mul_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
  end

  // Final result and flags from latched operands / iteration registers
  always_comb begin
    ext   = '0;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (op_q == OP_ADC) & cin_q};
        res_d = ext[WIDTH-1:0];
        c_d   = ext[WIDTH];
        v_d   = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_SBC: begin
        ext   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, (op_q == OP_SBC) & ~cin_q};
        res_d = ext[WIDTH-1:0];
        c_d   = ~ext[WIDTH];
        v_d   = (a_q[MSB] != b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOT:  res_d = ~a_q;
      OP_PSA:  res_d = a_q;
      OP_PSB:  res_d = b_q;
      OP_SHL1: begin res_d = {a_q[WIDTH-2:0], 1'b0};     c_d = a_q[MSB]; end
      OP_SHR1: begin res_d = {1'b0, a_q[WIDTH-1:1]};     c_d = a_q[0];   end
      OP_ASR1: begin res_d = {a_q[MSB], a_q[WIDTH-1:1]}; c_d = a_q[0];   end
      OP_ROL:  begin res_d = {a_q[WIDTH-2:0], cin_q};    c_d = a_q[MSB]; end
      OP_ROR:  begin res_d = {cin_q, a_q[WIDTH-1:1]};    c_d = a_q[0];   end
      OP_INC: begin
        ext   = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
        res_d = ext[WIDTH-1:0];
        c_d   = ext[WIDTH];
        v_d   = ~a_q[MSB] & res_d[MSB];
      end
      OP_DEC: begin
        ext   = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
        res_d = ext[WIDTH-1:0];
        c_d   = ext[WIDTH];
        v_d   = a_q[MSB] & ~res_d[MSB];
      end
      OP_SHLN, OP_SHRN: begin res_d = lo_q; c_d = sc_q; end
      OP_MUL: begin
        if (MUL_EN) begin
          res_d = lo_q;
          c_d   = |hi_q;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, operand latch, iteration datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      sc_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.in_1;
            b_q     <= bus.in_2;
            op_q    <= bus.select;
            cin_q   <= bus.carry_in;
            hi_q    <= '0;
            lo_q    <= mul_in ? bus.in_2 : bus.in_1;
            sc_q    <= 1'b0;
            cnt_q   <= mul_in ? CNT_WIDTH : {1'b0, bus.in_2[CW-1:0]};
            state_q <= multi_in ? RUN : DONE;
          end
        end
        RUN: begin
          // A zero shift count still spends one RUN cycle, with no shift
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (op_q == OP_MUL) begin
              {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
            end else if (op_q == OP_SHLN) begin
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
              sc_q <= lo_q[MSB];
            end else begin
              lo_q <= {1'b0, lo_q[WIDTH-1:1]};
              sc_q <= lo_q[0];
            end
          end
          if (cnt_q <= CNT_ONE) state_q <= DONE;
        end
        DONE: begin
          result_q <= res_d;
          c_q      <= c_d;
          z_q      <= (res_d == '0);
          n_q      <= res_d[MSB];
          v_q      <= v_d;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data      = bus.enable ? result_q : 'z;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.carry_out = c_q;
  assign bus.zero_flag = z_q;
  assign bus.neg_flag  = n_q;
  assign bus.ovf_flag  = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {data, carry, zero, neg, ovf}
  function automatic logic [19:0] obs();
    return {bus.data, bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag};
  endfunction

  // Issue one op; lat = posedges from the start edge until done is seen
  // (-1 on timeout), bc = sampled cycles with busy high.
  task automatic run_op(input logic [4:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input bit inject, output int lat, output int bc);
    @(negedge clk);
    bus.select = sel; bus.in_1 = a; bus.in_2 = b; bus.carry_in = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    bc  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bc++;
      if (inject && lat == 3) begin
        bus.select = 5'd0; bus.in_1 = 16'hFFFF; bus.in_2 = 16'hFFFF; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bus.busy, bus.done, obs()} !== 22'd0) $display("FAIL reset_state: got %h want 0", {bus.busy, bus.done, obs()});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.done, obs()} !== 22'd0) $display("FAIL reset_release: got %h want 0", {bus.busy, bus.done, obs()});
    else passed++;
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(5'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    total++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else passed++;
    total++;
    if (obs() !== {16'h0000, 4'b1100}) $display("FAIL add_wrap: got %h want %h", obs(), {16'h0000, 4'b1100});
    else passed++;
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.done); else passed++;
    run_op(5'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    total++;
    if (obs() !== {16'h8000, 4'b0011}) $display("FAIL add_ovf: got %h want %h", obs(), {16'h8000, 4'b0011});
    else passed++;
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(5'd2, 16'h0003, 16'h0005, 1'b0, 1'b0, lat, bc);
    total++;
    if (obs() !== {16'hFFFE, 4'b0010}) $display("FAIL sub_borrow: got %h want %h", obs(), {16'hFFFE, 4'b0010});
    else passed++;
    run_op(5'd3, 16'h0005, 16'h0003, 1'b0, 1'b0, lat, bc);
    total++;
    if (lat !== 1) $display("FAIL sbc_latency: got %0d want 1", lat); else passed++;
    total++;
    if (obs() !== {16'h0001, 4'b1000}) $display("FAIL sbc: got %h want %h", obs(), {16'h0001, 4'b1000});
    else passed++;
  endtask

  task automatic test_shift();
    int lat, bc;
    run_op(5'd17, 16'h8001, 16'h0004, 1'b0, 1'b0, lat, bc);
    total++;
    if (lat !== 5) $display("FAIL shln_latency: got %0d want 5", lat); else passed++;
    total++;
    if (bc !== 4) $display("FAIL shln_busy: got %0d want 4", bc); else passed++;
    total++;
    if (obs() !== {16'h0010, 4'b0000}) $display("FAIL shln: got %h want %h", obs(), {16'h0010, 4'b0000});
    else passed++;
    // count field is in_2[3:0]; 0x0010 gives N=0
    run_op(5'd18, 16'hA5A5, 16'h0010, 1'b1, 1'b0, lat, bc);
    total++;
    if (lat !== 2) $display("FAIL shrn0_latency: got %0d want 2", lat); else passed++;
    total++;
    if (obs() !== {16'hA5A5, 4'b0010}) $display("FAIL shrn0: got %h want %h", obs(), {16'hA5A5, 4'b0010});
    else passed++;
    run_op(5'd18, 16'hC000, 16'h000F, 1'b0, 1'b0, lat, bc);
    total++;
    if (lat !== 16) $display("FAIL shrn15_latency: got %0d want 16", lat); else passed++;
    total++;
    if (obs() !== {16'h0001, 4'b1000}) $display("FAIL shrn15: got %h want %h", obs(), {16'h0001, 4'b1000});
    else passed++;
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(5'd19, 16'h0100, 16'h0100, 1'b0, 1'b0, lat, bc);
    total++;
    if (lat !== 17) $display("FAIL mul_latency: got %0d want 17", lat); else passed++;
    total++;
    if (obs() !== {16'h0000, 4'b1100}) $display("FAIL mul_high: got %h want %h", obs(), {16'h0000, 4'b1100});
    else passed++;
    run_op(5'd19, 16'h0012, 16'h0034, 1'b0, 1'b1, lat, bc);
    total++;
    if (lat !== 17) $display("FAIL mul_inject_latency: got %0d want 17", lat); else passed++;
    total++;
    if (obs() !== {16'h03A8, 4'b0000}) $display("FAIL mul_inject: got %h want %h", obs(), {16'h03A8, 4'b0000});
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    bus.select = 5'd19; bus.in_1 = 16'h1234; bus.in_2 = 16'h5678; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL mid_run_busy: got %b want 1", bus.busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, obs()} !== 22'd0) $display("FAIL mid_run_reset: got %h want 0", {bus.busy, bus.done, obs()});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL mid_run_no_done: got %0d active cycles want 0", seen); else passed++;
  endtask

  task automatic test_bus_reserved();
    int lat, bc;
    run_op(5'd19, 16'h0012, 16'h0034, 1'b0, 1'b0, lat, bc);
    bus.enable = 1'b0;
    #1;
    // Undriven bus: 'z in four-state simulators, resolves to 0 in two-state ones
    total++;
    if (bus.data !== 16'hzzzz && bus.data !== 16'h0000) $display("FAIL bus_release: got %h want z", bus.data);
    else passed++;
    bus.enable = 1'b1;
    #1;
    total++;
    if (bus.data !== 16'h03A8) $display("FAIL bus_drive: got %h want 03a8", bus.data); else passed++;
    run_op(5'd25, 16'h1234, 16'h4321, 1'b1, 1'b0, lat, bc);
    total++;
    if (lat !== 1) $display("FAIL reserved_latency: got %0d want 1", lat); else passed++;
    total++;
    if (obs() !== {16'h0000, 4'b0100}) $display("FAIL reserved: got %h want %h", obs(), {16'h0000, 4'b0100});
    else passed++;
  endtask

  initial begin
    bus.in_1 = '0; bus.in_2 = '0; bus.select = '0;
    bus.carry_in = 1'b0; bus.start = 1'b0; bus.enable = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_mul();
    test_reset_mid_run();
    test_bus_reserved();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
